// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: byte/half/word access to a local data RAM with a
// configurable read latency, BEQ/BNE resolution and the MEM/WB pipeline register.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no load in flight; a legal load here captures the RAM word
//   WAIT  | load in flight; cnt counts down to the cycle that latches MEM/WB
module mem_stage_lsu #(
   parameter int NB_DATA     = 32,
   parameter int NB_ADDR     = 5,
   parameter int NB_MEM_ADDR = 10,
   parameter int RD_LATENCY  = 2
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_addr,
   input  logic [NB_DATA-1:0] i_rf_data,
   input  logic               i_wr_enable,
   input  logic               i_rd_enable,
   input  logic [1:0]         i_mem_size,
   input  logic               i_mem_unsigned,
   input  logic               i_is_branch,
   input  logic               i_branch_ne,
   input  logic               i_alu_zero,
   input  logic               i_rf_wr_enb,
   input  logic               i_rf_wr_data_src,
   input  logic [NB_ADDR-1:0] i_rf_wr_addr,
   output logic               o_stall,
   output logic               o_pc_source,
   output logic               o_misaligned,
   output logic [NB_DATA-1:0] o_data_readed_ltchd,
   output logic [NB_DATA-1:0] o_alu_result_ltchd,
   output logic               o_rf_wr_enb_ltchd,
   output logic               o_rf_wr_data_src_ltchd,
   output logic [NB_ADDR-1:0] o_rf_wr_addr_ltchd
);

   localparam int         MEM_DEPTH = 2 ** NB_MEM_ADDR;
   localparam int         NB_BADDR  = NB_MEM_ADDR + 2;
   localparam bit         HAS_WAIT  = (RD_LATENCY != 0);
   localparam logic [2:0] CNT_INIT  = (RD_LATENCY == 0) ? 3'd0 : 3'(RD_LATENCY - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                 state;
   logic [2:0]             cnt;
   logic [NB_DATA-1:0]     ram [MEM_DEPTH];
   logic [NB_MEM_ADDR-1:0] ram_addr;
   logic [NB_DATA-1:0]     rd_word;
   logic [1:0]             rd_lane;
   logic [1:0]             rd_size;
   logic                   rd_unsigned;
   logic                   size_illegal;
   logic                   addr_misaligned;
   logic                   access_bad;
   logic                   store_ok;
   logic                   load_ok;
   logic                   load_start;
   logic                   load_done;
   logic [3:0]             wr_be;
   logic [NB_DATA-1:0]     wr_data;
   logic [NB_DATA-1:0]     rd_comb;

   function automatic logic [NB_DATA-1:0] load_extend(
      input logic [NB_DATA-1:0] word,
      input logic [1:0]         lane,
      input logic [1:0]         size,
      input logic               zext
   );
      logic [NB_DATA-1:0] shifted;
      logic [7:0]         lb;
      logic [15:0]        lh;
      shifted = word >> {lane, 3'b000};
      lb      = shifted[7:0];
      lh      = lane[1] ? word[NB_DATA-1:NB_DATA-16] : word[15:0];
      case (size)
         2'b00:   load_extend = zext ? {{(NB_DATA-8){1'b0}}, lb}  : {{(NB_DATA-8){lb[7]}}, lb};
         2'b01:   load_extend = zext ? {{(NB_DATA-16){1'b0}}, lh} : {{(NB_DATA-16){lh[15]}}, lh};
         default: load_extend = word;
      endcase
   endfunction

   assign ram_addr        = i_addr[NB_BADDR-1:2];
   assign size_illegal    = (i_mem_size == 2'b11);
   assign addr_misaligned = ((i_mem_size == 2'b01) & i_addr[0]) |
                            ((i_mem_size == 2'b10) & (i_addr[1:0] != 2'b00));
   assign access_bad      = (i_wr_enable | i_rd_enable) & (size_illegal | addr_misaligned);
   assign store_ok        = i_wr_enable & ~access_bad;
   // A simultaneous store wins; the load request is dropped entirely.
   assign load_ok         = i_rd_enable & ~i_wr_enable & ~access_bad;
   assign load_start      = HAS_WAIT & (state == IDLE) & load_ok;
   assign load_done       = (state == WAIT) & (cnt == 3'd0);
   assign o_stall         = ~i_reset & (load_start | ((state == WAIT) & (cnt != 3'd0)));
   assign o_pc_source     = i_is_branch & (i_alu_zero ^ i_branch_ne);
   assign rd_comb         = load_extend(ram[ram_addr], i_addr[1:0], i_mem_size, i_mem_unsigned);

   always_comb begin
      wr_be   = 4'b0000;
      wr_data = i_rf_data;
      case (i_mem_size)
         2'b00: begin
            wr_be   = 4'b0001 << i_addr[1:0];
            wr_data = {4{i_rf_data[7:0]}};
         end
         2'b01: begin
            wr_be   = i_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{i_rf_data[15:0]}};
         end
         default: wr_be = 4'b1111;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (store_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) ram[ram_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state       <= IDLE;
         cnt         <= 3'd0;
         rd_word     <= '0;
         rd_lane     <= 2'b00;
         rd_size     <= 2'b00;
         rd_unsigned <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_start) begin
                  state       <= WAIT;
                  cnt         <= CNT_INIT;
                  rd_word     <= ram[ram_addr];
                  rd_lane     <= i_addr[1:0];
                  rd_size     <= i_mem_size;
                  rd_unsigned <= i_mem_unsigned;
               end
            end
            WAIT: begin
               if (cnt == 3'd0) state <= IDLE;
               else             cnt   <= cnt - 3'd1;
            end
         endcase
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_misaligned           <= 1'b0;
         o_data_readed_ltchd    <= '0;
         o_alu_result_ltchd     <= '0;
         o_rf_wr_enb_ltchd      <= 1'b0;
         o_rf_wr_data_src_ltchd <= 1'b0;
         o_rf_wr_addr_ltchd     <= '0;
      end else begin
         o_misaligned           <= access_bad;
         o_alu_result_ltchd     <= i_addr;
         o_rf_wr_data_src_ltchd <= i_rf_wr_data_src;
         o_rf_wr_addr_ltchd     <= i_rf_wr_addr;
         if (o_stall) begin
            o_rf_wr_enb_ltchd   <= 1'b0;
            o_data_readed_ltchd <= '0;
         end else if (load_done) begin
            o_rf_wr_enb_ltchd   <= i_rf_wr_enb;
            o_data_readed_ltchd <= load_extend(rd_word, rd_lane, rd_size, rd_unsigned);
         end else begin
            o_rf_wr_enb_ltchd   <= i_rf_wr_enb & ~access_bad;
            o_data_readed_ltchd <= load_ok ? rd_comb : '0;
         end
      end
   end

endmodule
